cache_control_dm: RTL and testbench
===================================

Name: cache_control_dm

Overview:
- FSM controller for the 8-set, direct-mapped, write-back/write-allocate L1 cache built around one cache_structure instance (dirty/valid/tag/data arrays, 256-bit lines).
- Sits between the CPU memory port and the cacheline adaptor.
- Decodes CPU requests and drives every structure control input.
- Sequences writeback and allocate bursts through the line-wide pmem interface, and keeps hit, miss and writeback counters.

Parameters:
- CNT_WIDTH, 16, width of each saturating performance counter.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-low reset
- mem_address  in  32  CPU byte address
- mem_read  in  1  CPU read request, held until mem_resp
- mem_write  in  1  CPU write request, held until mem_resp
- mem_byte_enable  in  4  write byte mask
- mem_wdata  in  32  write data
- mem_rdata  out  32  read data, valid with mem_resp
- mem_resp  out  1  one-cycle completion pulse
- pmem_address  out  32  line-aligned address to adaptor
- pmem_read  out  1  line fill request
- pmem_write  out  1  line writeback request
- pmem_wdata  out  256  writeback line
- pmem_rdata  in  256  fill line
- pmem_resp  in  1  adaptor completion pulse
- index  out  3  structure set index
- tag_in  out  24  structure tag write data
- dirty_in, valid_in  out  1 each  structure bit write data
- ld_dirty, ld_valid, ld_tag  out  1 each  structure load strobes
- write_enable256  out  32  per-byte data write enable
- data_in  out  256  structure line write data
- dirty_out, valid_out  in  1 each  structure bit read data
- tag_out  in  24  structure tag read data
- data_out  in  256  structure line read data
- hit_count, miss_count, wb_count  out  CNT_WIDTH each  performance counters

Behaviour:
- Address split:
  - tag = mem_address[31:8]
  - index = mem_address[7:5], driven combinationally at all times
  - word = mem_address[4:2]
- Structure reads are registered: outputs reflect index one cycle after it is presented.
- The requester holds address, data and request stable until mem_resp.
- mem_read and mem_write together are treated as a write.
- Default outputs, also the reset values:
  - all strobes, mem_resp, pmem_read and pmem_write = 0
  - write_enable256 = 0
  - counters = 0
  - state = IDLE
- Data outputs mem_rdata, pmem_wdata, pmem_address and data_in are don't-care unless noted; reset value is 0.
- IDLE:
  - Go to CHECK when mem_read or mem_write is seen.
- CHECK:
  - hit = valid_out && tag_out == tag.
  - Read hit:
    - mem_rdata = data_out[32*word +: 32]
    - mem_resp = 1, hit_count++, go to IDLE
  - Write hit:
    - write_enable256 = mem_byte_enable << (4*word)
    - data_in = mem_wdata replicated 8×
    - ld_dirty = 1 with dirty_in = 1
    - mem_resp = 1, hit_count++, go to IDLE
  - Miss with valid_out && dirty_out: miss_count++, go to WRITEBACK.
  - Miss otherwise: miss_count++, go to ALLOCATE.
- WRITEBACK:
  - pmem_write = 1
  - pmem_address = {tag_out, index, 5'b0}
  - pmem_wdata = data_out
  - Held until pmem_resp; then wb_count++, go to ALLOCATE.
- ALLOCATE:
  - pmem_read = 1
  - pmem_address = {tag, index, 5'b0}
  - On pmem_resp:
    - write_enable256 = all ones, data_in = pmem_rdata
    - ld_tag = 1 with tag_in = tag
    - ld_valid = 1 with valid_in = 1
    - ld_dirty = 1 with dirty_in = 0
    - go to REFILL
- REFILL:
  - One bubble cycle so the registered structure outputs reflect the new line, then go to CHECK.
  - CHECK then hits and completes the request; it is counted as a hit as well as the earlier miss.
- Latency:
  - hit: mem_resp in the cycle after the request is first seen in IDLE
  - clean miss: 1 + fill + 2 cycles
  - dirty miss: adds the writeback
- mem_resp is never asserted outside CHECK. At most one pmem request is asserted at a time.
- Counters saturate at all ones and do not wrap.
- Reset mid-operation returns to IDLE in the next cycle.
  - A pending pmem request is dropped.
  - Array contents are untouched by this block.
- pmem_resp outside WRITEBACK/ALLOCATE is ignored.

Test Plan:
- Cold read of 0x0000_0040 (set 2 invalid):
  - ALLOCATE requests pmem_address 0x0000_0040.
  - Return a line with word 0 = 0xDEAD_BEEF.
  - Required: mem_rdata = 0xDEAD_BEEF, miss_count = 1, hit_count = 1, no pmem_write.
- Read hit on 0x0000_0044 after the fill:
  - mem_resp in the cycle after the request.
  - mem_rdata = fill word 1.
  - hit_count = 2, no pmem activity.
- Write 0x0000_0048, byte_enable 0b0011, wdata 0x1234_5678:
  - write_enable256 = 0x0000_0300, ld_dirty = 1.
  - A following read of 0x0000_0048 returns 0xWWWW_5678, where WWWW is the upper half of fill word 2.
- Dirty eviction: read 0x0000_1040 (same set 2, different tag):
  - pmem_write first, at 0x0000_0040, with the modified line; wb_count = 1.
  - Then pmem_read at 0x0000_1040.
  - Required: dirty cleared, tag_in = 0x000010.
- Reset asserted (rst = 0) while in ALLOCATE with pmem_read high:
  - Next cycle: pmem_read = 0, state = IDLE, all counters = 0, no mem_resp.
- Counter saturation with CNT_WIDTH = 4:
  - Issue 17 hits; hit_count holds at 0xF.

Source files
------------

// File: rtl/cache_control_dm.sv
// Controller FSM for the 8-set direct-mapped write-back/write-allocate L1.
// It decodes CPU requests, drives the tag/dirty/valid/data structure strobes,
// sequences line writebacks and fills over pmem, and counts hits, misses
// and writebacks with saturating counters.
module cache_control_dm #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          mem_address,
    input  logic                 mem_read,
    input  logic                 mem_write,
    input  logic [3:0]           mem_byte_enable,
    input  logic [31:0]          mem_wdata,
    output logic [31:0]          mem_rdata,
    output logic                 mem_resp,
    output logic [31:0]          pmem_address,
    output logic                 pmem_read,
    output logic                 pmem_write,
    output logic [255:0]         pmem_wdata,
    input  logic [255:0]         pmem_rdata,
    input  logic                 pmem_resp,
    output logic [2:0]           index,
    output logic [23:0]          tag_in,
    output logic                 dirty_in,
    output logic                 valid_in,
    output logic                 ld_dirty,
    output logic                 ld_valid,
    output logic                 ld_tag,
    output logic [31:0]          write_enable256,
    output logic [255:0]         data_in,
    input  logic                 dirty_out,
    input  logic                 valid_out,
    input  logic [23:0]          tag_out,
    input  logic [255:0]         data_out,
    output logic [CNT_WIDTH-1:0] hit_count,
    output logic [CNT_WIDTH-1:0] miss_count,
    output logic [CNT_WIDTH-1:0] wb_count
);

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        WRITEBACK,
        ALLOCATE,
        REFILL
    } state_e;

    state_e               state_q, state_d;
    logic [CNT_WIDTH-1:0] hit_q, hit_d, miss_q, miss_d, wb_q, wb_d;

    logic [23:0] tag;
    logic [2:0]  word;
    logic        hit;
    logic        unused_addr;

    assign tag         = mem_address[31:8];
    assign word        = mem_address[4:2];
    assign index       = mem_address[7:5];
    assign hit         = valid_out && (tag_out == tag);
    assign unused_addr = &{1'b0, mem_address[1:0]};

    assign hit_count  = hit_q;
    assign miss_count = miss_q;
    assign wb_count   = wb_q;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (v == '1) ? v : v + CNT_WIDTH'(1);
    endfunction

    // Next-state, counter updates and per-state structure/pmem controls.
    // Outputs depend on the current state and the structure read data so a
    // hit completes in the CHECK cycle itself.
    always_comb begin
        state_d         = state_q;
        hit_d           = hit_q;
        miss_d          = miss_q;
        wb_d            = wb_q;
        mem_rdata       = '0;
        mem_resp        = 1'b0;
        pmem_address    = '0;
        pmem_read       = 1'b0;
        pmem_write      = 1'b0;
        pmem_wdata      = '0;
        tag_in          = '0;
        dirty_in        = 1'b0;
        valid_in        = 1'b0;
        ld_dirty        = 1'b0;
        ld_valid        = 1'b0;
        ld_tag          = 1'b0;
        write_enable256 = '0;
        data_in         = '0;
        case (state_q)
            IDLE: begin
                if (mem_read || mem_write) state_d = CHECK;
            end
            CHECK: begin
                if (hit) begin
                    // read+write together is handled as a write
                    if (mem_write) begin
                        write_enable256 = {28'b0, mem_byte_enable} << {word, 2'b00};
                        data_in         = {8{mem_wdata}};
                        ld_dirty        = 1'b1;
                        dirty_in        = 1'b1;
                    end else begin
                        mem_rdata = data_out[{word, 5'b0} +: 32];
                    end
                    mem_resp = 1'b1;
                    hit_d    = sat_inc(hit_q);
                    state_d  = IDLE;
                end else begin
                    miss_d  = sat_inc(miss_q);
                    state_d = (valid_out && dirty_out) ? WRITEBACK : ALLOCATE;
                end
            end
            WRITEBACK: begin
                pmem_write   = 1'b1;
                pmem_address = {tag_out, index, 5'b0};
                pmem_wdata   = data_out;
                if (pmem_resp) begin
                    wb_d    = sat_inc(wb_q);
                    state_d = ALLOCATE;
                end
            end
            ALLOCATE: begin
                pmem_read    = 1'b1;
                pmem_address = {tag, index, 5'b0};
                if (pmem_resp) begin
                    write_enable256 = '1;
                    data_in         = pmem_rdata;
                    ld_tag          = 1'b1;
                    tag_in          = tag;
                    ld_valid        = 1'b1;
                    valid_in        = 1'b1;
                    ld_dirty        = 1'b1;
                    dirty_in        = 1'b0;
                    state_d         = REFILL;
                end
            end
            REFILL: begin
                // structure reads are registered; wait one cycle for the new line
                state_d = CHECK;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and counter registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            hit_q   <= '0;
            miss_q  <= '0;
            wb_q    <= '0;
        end else begin
            state_q <= state_d;
            hit_q   <= hit_d;
            miss_q  <= miss_d;
            wb_q    <= wb_d;
        end
    end

endmodule

// File: tb/tb_cache_control_dm.sv
// Directed bench for cache_control_dm: a small registered-read structure
// model and a pmem adaptor model surround the controller; a vector table
// drives requests, and hand sequences cover reset-in-fill and saturation.
module tb_cache_control_dm;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [31:0]   mem_address;
    logic          mem_read, mem_write;
    logic [3:0]    mem_byte_enable;
    logic [31:0]   mem_wdata, mem_rdata;
    logic          mem_resp;
    logic [31:0]   pmem_address;
    logic          pmem_read, pmem_write;
    logic [255:0]  pmem_wdata, pmem_rdata;
    logic          pmem_resp;
    logic [2:0]    index;
    logic [23:0]   tag_in;
    logic          dirty_in, valid_in, ld_dirty, ld_valid, ld_tag;
    logic [31:0]   write_enable256;
    logic [255:0]  data_in;
    logic          dirty_out = 1'b0, valid_out = 1'b0;
    logic [23:0]   tag_out = '0;
    logic [255:0]  data_out = '0;
    logic [CW-1:0] hit_count, miss_count, wb_count;

    cache_control_dm #(.CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .mem_address(mem_address), .mem_read(mem_read),
        .mem_write(mem_write), .mem_byte_enable(mem_byte_enable), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_resp(mem_resp), .pmem_address(pmem_address),
        .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_wdata(pmem_wdata),
        .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp), .index(index), .tag_in(tag_in),
        .dirty_in(dirty_in), .valid_in(valid_in), .ld_dirty(ld_dirty), .ld_valid(ld_valid),
        .ld_tag(ld_tag), .write_enable256(write_enable256), .data_in(data_in),
        .dirty_out(dirty_out), .valid_out(valid_out), .tag_out(tag_out), .data_out(data_out),
        .hit_count(hit_count), .miss_count(miss_count), .wb_count(wb_count)
    );

    always #5 clk = ~clk;

    // Structure model: registered reads (old contents), byte-masked writes.
    logic [7:0]         s_dirty = '0;
    logic [7:0]         s_valid = '0;
    logic [7:0][23:0]   s_tag   = '0;
    logic [7:0][255:0]  s_data  = '0;
    always @(posedge clk) begin
        dirty_out <= s_dirty[index];
        valid_out <= s_valid[index];
        tag_out   <= s_tag[index];
        data_out  <= s_data[index];
        if (ld_dirty) s_dirty[index] <= dirty_in;
        if (ld_valid) s_valid[index] <= valid_in;
        if (ld_tag)   s_tag[index]   <= tag_in;
        for (int b = 0; b < 32; b++)
            if (write_enable256[b]) s_data[index][8*b +: 8] <= data_in[8*b +: 8];
    end

    // Backing memory: lines written back are remembered, others are generated.
    logic [255:0] pmem [logic [31:0]];

    function automatic logic [255:0] line_of(input logic [31:0] la);
        logic [255:0] l;
        if (pmem.exists(la)) return pmem[la];
        for (int w = 0; w < 8; w++)
            l[32*w +: 32] = {16'hF00D, la[15:8], 5'b0, 3'(w)};
        if (la == 32'h40) begin
            l[31:0]   = 32'hDEAD_BEEF;
            l[63:32]  = 32'hCAFE_0001;
            l[95:64]  = 32'hABCD_0002;
        end
        return l;
    endfunction

    int checks = 0, failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Results of the most recent request
    int           r_lat, r_npw, r_npr, r_both = 0;
    logic         r_done;
    logic [31:0]  r_rdata, r_we, r_pw_addr, r_pr_addr;
    logic [255:0] r_pw_data;
    logic         r_lddirty, r_fill_ld_dirty, r_fill_dirty;
    logic [23:0]  r_fill_tag;

    // Issue one CPU request and act as the pmem adaptor (response on the
    // third cycle of each burst) until mem_resp or the cycle budget expires.
    task automatic do_req(input logic rd, input logic wr, input logic [31:0] a,
                          input logic [3:0] be, input logic [31:0] wd);
        int   cnt;
        logic ppr, ppw;
        mem_read = rd; mem_write = wr; mem_address = a;
        mem_byte_enable = be; mem_wdata = wd;
        r_lat = 0; r_npw = 0; r_npr = 0; r_done = 0; cnt = 0; ppr = 0; ppw = 0;
        r_pw_addr = '0; r_pr_addr = '0; r_pw_data = '0;
        for (int c = 0; c < 100 && !r_done; c++) begin
            @(posedge clk); #1;
            r_lat++;
            pmem_resp = 1'b0;
            if (pmem_read && pmem_write) r_both++;
            if (pmem_write && !ppw) begin r_npw++; r_pw_addr = pmem_address; r_pw_data = pmem_wdata; end
            if (pmem_read && !ppr) begin r_npr++; r_pr_addr = pmem_address; end
            ppw = pmem_write; ppr = pmem_read;
            if (pmem_read || pmem_write) begin
                cnt++;
                if (cnt == 3) begin
                    cnt = 0;
                    pmem_resp = 1'b1;
                    if (pmem_write) pmem[pmem_address] = pmem_wdata;
                    else pmem_rdata = line_of(pmem_address);
                    #1;
                    if (ld_tag) begin
                        r_fill_tag = tag_in; r_fill_ld_dirty = ld_dirty; r_fill_dirty = dirty_in;
                    end
                end
            end
            if (mem_resp) begin
                r_done = 1; r_rdata = mem_rdata; r_we = write_enable256; r_lddirty = ld_dirty;
            end
        end
        if (!r_done) chk("req_timeout", 64'(a), 64'hFFFF_FFFF);
        @(posedge clk); #1;
        mem_read = 0; mem_write = 0; pmem_resp = 0;
    endtask

    typedef struct {
        logic        rd, wr;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        chk_rdata;
        logic [31:0] exp_rdata;
        int          exp_lat, exp_npw, exp_npr;
        logic [31:0] exp_pw_addr, exp_pr_addr;
        logic [3:0]  exp_hit, exp_miss, exp_wb;
        logic [31:0] exp_we;
    } vec_t;

    function automatic vec_t mk(logic rd, logic wr, logic [31:0] a, logic [3:0] be,
                                logic [31:0] wd, logic cr, logic [31:0] er, int lat,
                                int npw, logic [31:0] pwa, int npr, logic [31:0] pra,
                                logic [3:0] h, logic [3:0] m, logic [3:0] w, logic [31:0] we);
        vec_t v;
        v.rd = rd; v.wr = wr; v.addr = a; v.be = be; v.wdata = wd;
        v.chk_rdata = cr; v.exp_rdata = er; v.exp_lat = lat;
        v.exp_npw = npw; v.exp_pw_addr = pwa; v.exp_npr = npr; v.exp_pr_addr = pra;
        v.exp_hit = h; v.exp_miss = m; v.exp_wb = w; v.exp_we = we;
        return v;
    endfunction

    vec_t tbl [11];

    initial begin
        // rd wr addr be wdata chk rdata lat npw pw_addr npr pr_addr hit miss wb we
        tbl[0]  = mk(1, 0, 32'h40,   4'h0, 0,            1, 32'hDEAD_BEEF, 6, 0, 0,     1, 32'h40,   1,  1, 0, 0);
        tbl[1]  = mk(1, 0, 32'h44,   4'h0, 0,            1, 32'hCAFE_0001, 1, 0, 0,     0, 0,        2,  1, 0, 0);
        tbl[2]  = mk(0, 1, 32'h48,   4'h3, 32'h1234_5678, 0, 0,            1, 0, 0,     0, 0,        3,  1, 0, 32'h300);
        tbl[3]  = mk(1, 0, 32'h48,   4'h0, 0,            1, 32'hABCD_5678, 1, 0, 0,     0, 0,        4,  1, 0, 0);
        tbl[4]  = mk(1, 0, 32'h1040, 4'h0, 0,            1, 32'hF00D_1000, 9, 1, 32'h40, 1, 32'h1040, 5,  2, 1, 0);
        tbl[5]  = mk(0, 1, 32'h2064, 4'hF, 32'hAABB_CCDD, 0, 0,            6, 0, 0,     1, 32'h2060, 6,  3, 1, 32'hF0);
        tbl[6]  = mk(1, 0, 32'h2064, 4'h0, 0,            1, 32'hAABB_CCDD, 1, 0, 0,     0, 0,        7,  3, 1, 0);
        tbl[7]  = mk(1, 1, 32'h2068, 4'h8, 32'h7700_0000, 0, 0,            1, 0, 0,     0, 0,        8,  3, 1, 32'h800);
        tbl[8]  = mk(1, 0, 32'h2068, 4'h0, 0,            1, 32'h770D_2002, 1, 0, 0,     0, 0,        9,  3, 1, 0);
        tbl[9]  = mk(1, 0, 32'h40,   4'h0, 0,            1, 32'hDEAD_BEEF, 6, 0, 0,     1, 32'h40,   10, 4, 1, 0);
        tbl[10] = mk(1, 0, 32'h48,   4'h0, 0,            1, 32'hABCD_5678, 1, 0, 0,     0, 0,        11, 4, 1, 0);

        rst = 0; mem_read = 0; mem_write = 0; mem_address = 0; mem_byte_enable = 0;
        mem_wdata = 0; pmem_resp = 0; pmem_rdata = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1;
        chk("reset_mem_resp", 64'(mem_resp), 0);
        chk("reset_pmem_req", 64'({pmem_read, pmem_write}), 0);
        chk("reset_counters", 64'({hit_count, miss_count, wb_count}), 0);
        chk("reset_we", 64'(write_enable256), 0);

        for (int i = 0; i < 11; i++) begin
            do_req(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].be, tbl[i].wdata);
            chk($sformatf("v%0d_latency", i), 64'(r_lat), 64'(tbl[i].exp_lat));
            if (tbl[i].chk_rdata) chk($sformatf("v%0d_rdata", i), 64'(r_rdata), 64'(tbl[i].exp_rdata));
            chk($sformatf("v%0d_we", i), 64'(r_we), 64'(tbl[i].exp_we));
            chk($sformatf("v%0d_ld_dirty", i), 64'(r_lddirty), 64'(tbl[i].wr));
            chk($sformatf("v%0d_npw", i), 64'(r_npw), 64'(tbl[i].exp_npw));
            chk($sformatf("v%0d_npr", i), 64'(r_npr), 64'(tbl[i].exp_npr));
            if (tbl[i].exp_npw > 0) chk($sformatf("v%0d_pw_addr", i), 64'(r_pw_addr), 64'(tbl[i].exp_pw_addr));
            if (tbl[i].exp_npr > 0) chk($sformatf("v%0d_pr_addr", i), 64'(r_pr_addr), 64'(tbl[i].exp_pr_addr));
            chk($sformatf("v%0d_counts", i), 64'({hit_count, miss_count, wb_count}),
                64'({tbl[i].exp_hit, tbl[i].exp_miss, tbl[i].exp_wb}));
            if (i == 4) begin
                chk("evict_wdata_w0", 64'(r_pw_data[31:0]), 64'h0000_0000_DEAD_BEEF);
                chk("evict_wdata_w2", 64'(r_pw_data[95:64]), 64'h0000_0000_ABCD_5678);
                chk("fill_tag_in", 64'(r_fill_tag), 64'h10);
                chk("fill_dirty_clear", 64'({r_fill_ld_dirty, r_fill_dirty}), 64'b10);
            end
        end

        // Reset while a fill is outstanding
        mem_read = 1; mem_address = 32'h3080;
        for (int c = 0; c < 20 && !pmem_read; c++) begin @(posedge clk); #1; end
        chk("rst_fill_started", 64'(pmem_read), 1);
        rst = 0; mem_read = 0;
        @(posedge clk); #1;
        chk("rst_pmem_read_dropped", 64'(pmem_read), 0);
        chk("rst_no_resp", 64'(mem_resp), 0);
        chk("rst_counters", 64'({hit_count, miss_count, wb_count}), 0);
        rst = 1;
        @(posedge clk); #1;
        chk("rst_idle_quiet", 64'({pmem_read, pmem_write, mem_resp}), 0);

        // Saturation: 17 hits on a resident line with 4-bit counters
        do_req(1, 0, 32'h44, 4'h0, 0);
        chk("sat_first_hit_lat", 64'(r_lat), 1);
        chk("sat_first_rdata", 64'(r_rdata), 64'hCAFE_0001);
        chk("sat_first_count", 64'(hit_count), 1);
        for (int k = 0; k < 16; k++) do_req(1, 0, 32'h44, 4'h0, 0);
        chk("sat_hit_count", 64'(hit_count), 64'hF);
        chk("sat_miss_count", 64'(miss_count), 0);
        chk("one_pmem_req", 64'(r_both), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
